ram_arb2: RTL and testbench

RAM_ARB2 -- requirements
Module: ram_arb2

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb2_rr_arb2.sv | 25 ++
 rtl/ram_arb2.sv | 152 +++++++++++++++
 tb/tb_ram_arb2.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM state encoding and
// default geometry of the RAM port.
package ram_arb_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 15;
  localparam int unsigned ARB_DATA_WIDTH = 32;
  localparam int unsigned ARB_RD_LAT     = 1;

  // Wide enough to hold the largest legal read latency (4).
  localparam int unsigned ARB_CNT_WIDTH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ram_arb2_rr_arb2.sv
// Two-way round-robin selector. The pointer is held by the caller; this block
// picks a winner and returns the pointer value to store.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o,
  output logic       last_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      // Tie: the master that was not granted last time wins.
      2'b11:   gnt_idx_o = ~last_i;
      default: gnt_idx_o = 1'b0;
    endcase
    last_o = (update_i && gnt_valid_o) ? gnt_idx_o : last_i;
  end

endmodule

// File: rtl/ram_arb2.sv
// Two-master arbiter in front of a single-port RAM with fixed read latency.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x RD_LAT -> RESP) -> IDLE.
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned RD_LAT     = ARB_RD_LAT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    m0_valid_i,
  output logic                    m0_ready_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_rvalid_o,

  input  logic                    m1_valid_i,
  output logic                    m1_ready_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_rvalid_o,

  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] ram_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

  output logic                    busy_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_e                 state_q, state_d;
  logic [ARB_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                       win_q, win_d;
  logic                       last_q, last_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]      wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]      rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]      rdata1_q, rdata1_d;

  logic                       arb_update;
  logic                       gnt_valid;
  logic                       gnt_idx;

  // Pointer only moves when a grant is actually taken in IDLE.
  assign arb_update = (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req_i       ({m1_valid_i, m0_valid_i}),
    .last_i      (last_q),
    .update_i    (arb_update),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .last_o      (last_d)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          win_d   = gnt_idx;
          addr_d  = gnt_idx ? m1_addr_i  : m0_addr_i;
          wdata_d = gnt_idx ? m1_wdata_i : m0_wdata_i;
          wstrb_d = gnt_idx ? m1_wstrb_i : m0_wstrb_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wstrb_q == '0) begin
          cnt_d   = ARB_CNT_WIDTH'(RD_LAT);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // RAM data is valid during the last WAIT cycle; capture it here so
        // RESP presents registered data alongside the rvalid pulse.
        if (cnt_q == ARB_CNT_WIDTH'(1)) begin
          if (win_q) begin
            rdata1_d = ram_rdata_i;
          end else begin
            rdata0_d = ram_rdata_i;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_wstrb_o = (state_q == ST_ISSUE) ? wstrb_q : '0;

  assign m0_ready_o  = (state_q == ST_ISSUE) && !win_q;
  assign m1_ready_o  = (state_q == ST_ISSUE) &&  win_q;
  assign m0_rvalid_o = (state_q == ST_RESP)  && !win_q;
  assign m1_rvalid_o = (state_q == ST_RESP)  &&  win_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_arb2.sv
// Bench for ram_arb2: a RD_LAT=1 instance with a byte-writable RAM model and a
// RD_LAT=4 instance in front of an address-derived ROM.
module tb_ram_arb2;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int RD1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          m0_valid, m0_ready, m0_rvalid, m1_valid, m1_ready, m1_rvalid, busy;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb, ram_wstrb;

  logic          f_m0_valid, f_m0_ready, f_m0_rvalid, f_m1_valid, f_m1_ready, f_m1_rvalid, f_busy;
  logic [AW-1:0] f_m0_addr, f_m1_addr, f_ram_addr;
  logic [DW-1:0] f_m0_wdata, f_m1_wdata, f_m0_rdata, f_m1_rdata, f_ram_wdata, f_ram_rdata;
  logic [SW-1:0] f_m0_wstrb, f_m1_wstrb, f_ram_wstrb;

  ram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wstrb_o(ram_wstrb),
    .ram_rdata_i(ram_rdata), .busy_o(busy)
  );

  ram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(f_m0_valid), .m0_ready_o(f_m0_ready), .m0_addr_i(f_m0_addr),
    .m0_wdata_i(f_m0_wdata), .m0_wstrb_i(f_m0_wstrb), .m0_rdata_o(f_m0_rdata), .m0_rvalid_o(f_m0_rvalid),
    .m1_valid_i(f_m1_valid), .m1_ready_o(f_m1_ready), .m1_addr_i(f_m1_addr),
    .m1_wdata_i(f_m1_wdata), .m1_wstrb_i(f_m1_wstrb), .m1_rdata_o(f_m1_rdata), .m1_rvalid_o(f_m1_rvalid),
    .ram_addr_o(f_ram_addr), .ram_wdata_o(f_ram_wdata), .ram_wstrb_o(f_ram_wstrb),
    .ram_rdata_i(f_ram_rdata), .busy_o(f_busy)
  );

  initial forever #5 clk = ~clk;

  // Synchronous RAM, one cycle read latency, with a bench-side preload port.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) begin
      ram_mem[pre_addr] <= pre_data;
    end else if (ram_wstrb != '0) begin
      for (int b = 0; b < SW; b++)
        if (ram_wstrb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= ram_mem[ram_addr];
  end

  // Four-cycle ROM for the RD_LAT=4 instance: data = C0DE0000 ^ addr.
  logic [DW-1:0] f_pipe [0:3];
  always @(posedge clk) begin
    f_pipe[0] <= 32'hC0DE_0000 ^ DW'(f_ram_addr);
    for (int i = 1; i < 4; i++) f_pipe[i] <= f_pipe[i-1];
  end
  assign f_ram_rdata = f_pipe[3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  typedef struct {
    logic          m;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          pre_en;
    logic [DW-1:0] pre;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          vecs [8];
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] ref_mem [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rec;
    logic is_rd;
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    f_m0_valid = 0; f_m0_addr = '0; f_m0_wdata = '0; f_m0_wstrb = '0;
    f_m1_valid = 0; f_m1_addr = '0; f_m1_wdata = '0; f_m1_wstrb = '0;

    vecs[0] = '{1'b0, 15'h0010, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 15'h7FFF, 32'h12345678, 4'h5, 1'b1, 32'hAAAAAAAA, 32'h0};
    vecs[2] = '{1'b1, 15'h7FFF, 32'h0,        4'h0, 1'b0, 32'h0,        32'hAA34AA78};
    vecs[3] = '{1'b0, 15'h0003, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        32'h0};
    vecs[4] = '{1'b0, 15'h0003, 32'h0,        4'h0, 1'b0, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b1, 15'h0010, 32'h0,        4'h0, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{1'b0, 15'h0001, 32'h11223344, 4'h8, 1'b1, 32'h0,        32'h0};
    vecs[7] = '{1'b1, 15'h0001, 32'h0,        4'h0, 1'b0, 32'h0,        32'h11000000};

    // Reset state of both instances.
    do_reset();
    @(negedge clk);
    chk("rst_ready", {f_m1_ready, f_m0_ready, m1_ready, m0_ready}, 0);
    chk("rst_rvalid", {f_m1_rvalid, f_m0_rvalid, m1_rvalid, m0_rvalid}, 0);
    chk("rst_busy", {f_busy, busy}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    chk("rst_rdata4", {f_m1_rdata, f_m0_rdata}, 0);
    chk("rst_ram", {ram_wstrb, ram_addr, ram_wdata}, 0);
    chk("rst_ram4", {f_ram_wstrb, f_ram_addr, f_ram_wdata}, 0);
    @(posedge clk); #1;
    exp_rd[0] = '0; exp_rd[1] = '0;

    // Single transactions from idle, RD_LAT=1.
    for (int i = 0; i < 8; i++) begin
      rec = vecs[i];
      is_rd = (rec.wstrb == '0);
      if (rec.pre_en) preload(rec.addr, rec.pre);
      if (rec.m) begin
        m1_valid = 1; m1_addr = rec.addr; m1_wdata = rec.wdata; m1_wstrb = rec.wstrb;
      end else begin
        m0_valid = 1; m0_addr = rec.addr; m0_wdata = rec.wdata; m0_wstrb = rec.wstrb;
      end
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 3 && is_rd) exp_rd[rec.m] = rec.exp_rdata;
        chk($sformatf("v%0d_c%0d_ready0", i, k), m0_ready, k == 1 && !rec.m);
        chk($sformatf("v%0d_c%0d_ready1", i, k), m1_ready, k == 1 && rec.m);
        chk($sformatf("v%0d_c%0d_rvalid0", i, k), m0_rvalid, is_rd && k == 3 && !rec.m);
        chk($sformatf("v%0d_c%0d_rvalid1", i, k), m1_rvalid, is_rd && k == 3 && rec.m);
        chk($sformatf("v%0d_c%0d_busy", i, k), busy, k >= 1 && (is_rd ? k <= 3 : k <= 1));
        chk($sformatf("v%0d_c%0d_wstrb", i, k), ram_wstrb, (k == 1) ? rec.wstrb : 4'h0);
        chk($sformatf("v%0d_c%0d_rdata0", i, k), m0_rdata, exp_rd[0]);
        chk($sformatf("v%0d_c%0d_rdata1", i, k), m1_rdata, exp_rd[1]);
        if (k == 1) begin
          chk($sformatf("v%0d_addr", i), ram_addr, rec.addr);
          if (!is_rd) chk($sformatf("v%0d_wdata", i), ram_wdata, rec.wdata);
        end
        @(posedge clk); #1;
        if (k == 1) begin
          m0_valid = 0; m1_valid = 0;
        end
      end
    end

    // Both masters hold reads continuously: grants must alternate from m0.
    do_reset();
    preload(15'h0020, 32'h0A0A0A0A);
    preload(15'h0021, 32'h0B0B0B0B);
    m0_valid = 1; m0_addr = 15'h0020; m0_wstrb = '0;
    m1_valid = 1; m1_addr = 15'h0021; m1_wstrb = '0;
    begin
      int g, rv;
      logic [3:0] exp_order;
      exp_order = 4'b1010;
      g = 0; rv = 0;
      for (int c = 0; c < 40 && rv < 4; c++) begin
        @(negedge clk);
        if (m0_ready && m1_ready) chk("both_ready", 1, 0);
        if (m0_rvalid && m1_rvalid) chk("both_rvalid", 1, 0);
        if ((m0_ready || m1_ready) && g < 4) begin
          chk($sformatf("rr_grant%0d", g), m1_ready, exp_order[g]);
          g++;
        end
        if ((m0_rvalid || m1_rvalid) && rv < 4) begin
          chk($sformatf("rr_rvalid%0d_route", rv), m1_rvalid, exp_order[rv]);
          if (m0_rvalid) chk($sformatf("rr_rdata%0d", rv), m0_rdata, 32'h0A0A0A0A);
          else           chk($sformatf("rr_rdata%0d", rv), m1_rdata, 32'h0B0B0B0B);
          rv++;
        end
        @(posedge clk); #1;
      end
      m0_valid = 0; m1_valid = 0;
      chk("rr_grants_seen", g, 4);
      chk("rr_rvalids_seen", rv, 4);
    end
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic against a transaction-scheduling reference model.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      preload(15'h0100 + 15'(i), ref_mem[i]);
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    begin
      int next_arb, issue_cyc, resp_cyc;
      logic last, win;
      logic pend [2];
      logic [AW-1:0] p_addr [2];
      logic [DW-1:0] p_wdata [2];
      logic [SW-1:0] p_wstrb [2];
      logic [AW-1:0] cur_addr;
      logic [DW-1:0] cur_wdata, rd_val;
      logic [SW-1:0] cur_wstrb;
      int idx;
      next_arb = 0; issue_cyc = -1; resp_cyc = -1; last = 1'b1; win = 1'b0;
      cur_addr = '0; cur_wdata = '0; cur_wstrb = '0; rd_val = '0;
      pend[0] = 0; pend[1] = 0;
      for (int m = 0; m < 2; m++) begin
        p_addr[m] = '0; p_wdata[m] = '0; p_wstrb[m] = '0;
      end
      for (int k = 0; k < 2000; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (!pend[m] && $urandom_range(0, 2) == 0) begin
            pend[m]    = 1'b1;
            p_addr[m]  = 15'h0100 + 15'($urandom_range(0, 7));
            p_wdata[m] = $urandom;
            p_wstrb[m] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          end
        end
        m0_valid = pend[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0]; m0_wstrb = p_wstrb[0];
        m1_valid = pend[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1]; m1_wstrb = p_wstrb[1];
        if (k >= next_arb && (pend[0] || pend[1])) begin
          win       = (pend[0] && pend[1]) ? ~last : pend[1];
          last      = win;
          issue_cyc = k + 1;
          cur_addr  = p_addr[win];
          cur_wdata = p_wdata[win];
          cur_wstrb = p_wstrb[win];
          idx       = int'(cur_addr) - 'h100;
          if (cur_wstrb == '0) begin
            rd_val   = ref_mem[idx];
            resp_cyc = k + RD1 + 2;
            next_arb = k + RD1 + 3;
          end else begin
            for (int b = 0; b < SW; b++)
              if (cur_wstrb[b]) ref_mem[idx][8*b +: 8] = cur_wdata[8*b +: 8];
            resp_cyc = -1;
            next_arb = k + 2;
          end
        end
        @(negedge clk);
        if (k == resp_cyc) exp_rd[win] = rd_val;
        chk("rnd_ready0", m0_ready, k == issue_cyc && !win);
        chk("rnd_ready1", m1_ready, k == issue_cyc && win);
        chk("rnd_rvalid0", m0_rvalid, k == resp_cyc && !win);
        chk("rnd_rvalid1", m1_rvalid, k == resp_cyc && win);
        chk("rnd_busy", busy, k >= issue_cyc && k < next_arb);
        chk("rnd_wstrb", ram_wstrb, (k == issue_cyc) ? cur_wstrb : 4'h0);
        chk("rnd_rdata0", m0_rdata, exp_rd[0]);
        chk("rnd_rdata1", m1_rdata, exp_rd[1]);
        if (k == issue_cyc) begin
          chk("rnd_addr", ram_addr, cur_addr);
          pend[win] = 1'b0;
        end
        @(posedge clk); #1;
      end
      m0_valid = 0; m1_valid = 0;
    end
    repeat (6) @(posedge clk);
    #1;

    // RD_LAT=4 read: four WAIT cycles, rvalid at cycle 6.
    f_m0_valid = 1; f_m0_addr = 15'h0042; f_m0_wstrb = '0; f_m0_wdata = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("l4_c%0d_ready0", k), f_m0_ready, k == 1);
      chk($sformatf("l4_c%0d_rvalid0", k), f_m0_rvalid, k == 6);
      chk($sformatf("l4_c%0d_rvalid1", k), f_m1_rvalid, 0);
      chk($sformatf("l4_c%0d_busy", k), f_busy, k >= 1 && k <= 6);
      chk($sformatf("l4_c%0d_wstrb", k), f_ram_wstrb, 0);
      chk($sformatf("l4_c%0d_rdata0", k), f_m0_rdata, (k >= 6) ? 32'hC0DE0042 : 32'h0);
      @(posedge clk); #1;
      if (k == 1) f_m0_valid = 0;
    end

    // Reset while waiting on read data aborts the read.
    f_m1_valid = 1; f_m1_addr = 15'h0011; f_m1_wstrb = '0;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) f_m1_valid = 0;
      if (k == 3) rst = 1'b1;
      if (k == 4) rst = 1'b0;
      @(negedge clk);
      if (k == 3) chk("ra_busy_in_wait", f_busy, 1);
      if (k >= 4) begin
        chk($sformatf("ra_c%0d_busy", k), f_busy, 0);
        chk($sformatf("ra_c%0d_rvalid", k), {f_m1_rvalid, f_m0_rvalid}, 0);
        chk($sformatf("ra_c%0d_rdata0", k), f_m0_rdata, 0);
        chk($sformatf("ra_c%0d_rdata1", k), f_m1_rdata, 0);
      end
      @(posedge clk); #1;
    end
    f_m0_valid = 1; f_m0_addr = 15'h0005;
    f_m1_valid = 1; f_m1_addr = 15'h0006;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ra_tie_ready0", f_m0_ready, 1);
    chk("ra_tie_ready1", f_m1_ready, 0);
    @(posedge clk); #1;
    f_m0_valid = 0; f_m1_valid = 0;
    begin
      int n;
      n = 0;
      while (f_busy && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("ra_drain", f_busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
